// File: rtl/crgu_seq_ctrl.sv
// Ordered power-up/power-down sequencer for CRGU leaf clock/reset domains, always-on 32k clock.
// Latency: one channel step = 1 start cycle + RST_HOLD hold cycles + step_dly idle cycles; masked channels take 1 cycle.
// No backpressure: level-driven by seq_start, outputs are registered enables/resets (scan_mode override is combinational).
//
// Ports:
//   clk_32k, rst_32k_alon_n : always-on clock and asynchronous active-low reset
//   scan_mode               : forces all clock enables on and resets to follow rst_32k_alon_n
//   seq_start               : 1 = bring up / stay up, 0 = bring down
//   ch_en                   : channel mask sampled at each up-step start
//   step_dly                : extra idle cycles after each channel step
//   soft_rst_req            : per-channel soft reset pulses, honoured only while running
//   ch_clk_en, ch_rst_n     : per-channel leaf ICG enable and active-low reset
//   seq_busy, seq_done      : sequencing in progress / all channels up
//   cur_ch                  : channel pointer currently being stepped

module crgu_seq_ctrl #(
  parameter int NCH      = 8,
  parameter int CNT_W    = 8,
  parameter int RST_HOLD = 4
) (
  input  logic                    clk_32k,
  input  logic                    rst_32k_alon_n,
  input  logic                    scan_mode,
  input  logic                    seq_start,
  input  logic [NCH-1:0]          ch_en,
  input  logic [CNT_W-1:0]        step_dly,
  input  logic [NCH-1:0]          soft_rst_req,
  output logic [NCH-1:0]          ch_clk_en,
  output logic [NCH-1:0]          ch_rst_n,
  output logic                    seq_busy,
  output logic                    seq_done,
  output logic [$clog2(NCH)-1:0]  cur_ch
);

  localparam int PTR_W  = $clog2(NCH);
  localparam int SCNT_W = $clog2(RST_HOLD + 1);

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NCH - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [SCNT_W-1:0] SOFT_INIT = SCNT_W'(RST_HOLD);

  typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_RUN, ST_DOWN} state_t;
  // PH_S: step start, PH_A: clk/reset hold, PH_B: step_dly idle, PH_F: final advance cycle
  typedef enum logic [1:0] {PH_S, PH_A, PH_B, PH_F} phase_t;

  state_t                   state_q, state_d;
  phase_t                   phase_q, phase_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NCH-1:0]           clk_en_q, clk_en_d;
  logic [NCH-1:0]           rst_n_q, rst_n_d;
  logic [NCH-1:0][SCNT_W-1:0] scnt_q, scnt_d;
  logic                     step_done;

  always_ff @(posedge clk_32k or negedge rst_32k_alon_n) begin
    if (!rst_32k_alon_n) begin
      state_q  <= ST_IDLE;
      phase_q  <= PH_S;
      ptr_q    <= '0;
      cnt_q    <= '0;
      clk_en_q <= '0;
      rst_n_q  <= '0;
      scnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
      rst_n_q  <= rst_n_d;
      scnt_q   <= scnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    clk_en_d  = clk_en_q;
    rst_n_d   = rst_n_q;
    scnt_d    = scnt_q;
    step_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (seq_start) begin
          state_d = ST_UP;
          phase_d = PH_S;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end

      ST_UP: begin
        if (!seq_start) begin
          // Abort: tear down from the current channel; DOWN skips anything not clocked.
          state_d = ST_DOWN;
          phase_d = PH_S;
          cnt_d   = '0;
        end else begin
          case (phase_q)
            PH_S: begin
              if (ch_en[ptr_q]) begin
                clk_en_d[ptr_q] = 1'b1;
                phase_d         = PH_A;
                cnt_d           = '0;
              end else begin
                step_done = 1'b1;
              end
            end
            PH_A: begin
              if (cnt_q == HOLD_LAST) begin
                rst_n_d[ptr_q] = 1'b1;
                phase_d        = PH_B;
                cnt_d          = CNT_W'(1);
                step_done      = (step_dly == '0);
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
            PH_B: begin
              // >= rather than == so a step_dly lowered mid-wait cannot wrap the counter
              if (cnt_q >= step_dly) step_done = 1'b1;
              else                   cnt_d = cnt_q + CNT_W'(1);
            end
            default: begin
              state_d = ST_RUN;
              phase_d = PH_S;
            end
          endcase
          if (step_done) begin
            cnt_d = '0;
            if (ptr_q == PTR_LAST) begin
              phase_d = PH_F;
            end else begin
              ptr_d   = ptr_q + PTR_W'(1);
              phase_d = PH_S;
            end
          end
        end
      end

      ST_RUN: begin
        if (!seq_start) begin
          // Pending soft-reset pulses are dropped; DOWN keeps those resets asserted.
          state_d = ST_DOWN;
          phase_d = PH_S;
          ptr_d   = PTR_LAST;
          cnt_d   = '0;
          scnt_d  = '0;
        end else begin
          for (int i = 0; i < NCH; i++) begin
            // Only channels actually clocked may be soft-reset, so the rst/clk invariant holds.
            if (soft_rst_req[i] && clk_en_q[i]) begin
              rst_n_d[i] = 1'b0;
              scnt_d[i]  = SOFT_INIT;
            end else if (scnt_q[i] != '0) begin
              if (scnt_q[i] == SCNT_W'(1)) rst_n_d[i] = 1'b1;
              scnt_d[i] = scnt_q[i] - SCNT_W'(1);
            end
          end
        end
      end

      default: begin // ST_DOWN; seq_start is ignored until the sequence reaches IDLE
        case (phase_q)
          PH_S: begin
            if (clk_en_q[ptr_q]) begin
              rst_n_d[ptr_q] = 1'b0;
              phase_d        = PH_A;
              cnt_d          = '0;
            end else begin
              step_done = 1'b1;
            end
          end
          PH_A: begin
            if (cnt_q == HOLD_LAST) begin
              clk_en_d[ptr_q] = 1'b0;
              phase_d         = PH_B;
              cnt_d           = CNT_W'(1);
              step_done       = (step_dly == '0);
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          PH_B: begin
            if (cnt_q >= step_dly) step_done = 1'b1;
            else                   cnt_d = cnt_q + CNT_W'(1);
          end
          default: begin
            state_d = ST_IDLE;
            phase_d = PH_S;
          end
        endcase
        if (step_done) begin
          cnt_d = '0;
          if (ptr_q == '0) begin
            phase_d = PH_F;
          end else begin
            ptr_d   = ptr_q - PTR_W'(1);
            phase_d = PH_S;
          end
        end
      end
    endcase
  end

  // Scan forces every leaf clock on and hands resets straight to the always-on reset.
  assign ch_clk_en = scan_mode ? {NCH{1'b1}} : clk_en_q;
  assign ch_rst_n  = scan_mode ? {NCH{rst_32k_alon_n}} : rst_n_q;
  assign seq_busy  = (state_q == ST_UP) || (state_q == ST_DOWN);
  assign seq_done  = (state_q == ST_RUN);
  assign cur_ch    = ptr_q;

endmodule
